// File: rtl/bc_result_line_streamer.sv
// bc_result_line_streamer: latches a strike/ball result, converts it to decimal and streams an LCD text line
module bc_result_line_streamer #(
  parameter int CNT_W       = 3,
  parameter int LINE_LEN    = 16,
  parameter int WIN_STRIKES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            strike_count_i,
  input  logic [CNT_W-1:0]            ball_count_i,
  output logic [7:0]                  char_data_o,
  output logic                        char_valid_o,
  input  logic                        char_ready_i,
  output logic [$clog2(LINE_LEN)-1:0] char_idx_o,
  output logic                        busy_o,
  output logic                        done_o
);
  localparam int IW = $clog2(LINE_LEN);
  localparam int DW = CNT_W + 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_COMP = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;
  localparam logic [63:0] HOME  = "HOMERUN!";
  localparam logic [23:0] OUT_S = "OUT";
  localparam logic [55:0] STR   = "STRIKE ";
  localparam logic [47:0] BAL   = " BALL ";

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [2:0]            cnt_q;
  logic                  go_q, done_q;
  logic [CNT_W-1:0]      strike_q, ball_q;
  logic [DW-1:0]         s_dd_q, b_dd_q;
  logic [LINE_LEN*8-1:0] line_q;
  logic [32*8-1:0]       msg;
  logic [7:0]            s_bcd, b_bcd;
  logic                  accept, xfer, last_idx;
  int                    p;

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift the whole register left
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] v);
    logic [DW-1:0] t;
    t = v;
    if (t[CNT_W+3:CNT_W] >= 4'd5) t[CNT_W+3:CNT_W] = t[CNT_W+3:CNT_W] + 4'd3;
    if (t[CNT_W+7:CNT_W+4] >= 4'd5) t[CNT_W+7:CNT_W+4] = t[CNT_W+7:CNT_W+4] + 4'd3;
    return t << 1;
  endfunction

  // Start is registered first so the line appears CNT_W+2 edges after the accepting edge
  assign accept       = state_q == S_IDLE && !go_q && start_i;
  assign s_bcd        = s_dd_q[DW-1:CNT_W];
  assign b_bcd        = b_dd_q[DW-1:CNT_W];
  assign char_valid_o = state_q == S_EMIT;
  assign char_data_o  = char_valid_o ? line_q[8*idx_q +: 8] : 8'h00;
  assign char_idx_o   = idx_q;
  assign busy_o       = state_q != S_IDLE;
  assign done_o       = done_q;
  assign xfer         = char_valid_o && char_ready_i;
  assign last_idx     = idx_q == IW'(LINE_LEN - 1);

  // Next state and column counter
  always_comb begin
    state_d = state_q == S_IDLE ? (go_q ? S_CONV : S_IDLE) :
              state_q == S_CONV ? (cnt_q == 3'(CNT_W - 1) ? S_COMP : S_CONV) :
              state_q == S_COMP ? S_EMIT : (xfer && last_idx ? S_IDLE : S_EMIT);
    idx_d   = xfer ? (last_idx ? '0 : idx_q + 1'b1) : idx_q;
  end

  // Compose the text in a 32-column scratch line; columns past LINE_LEN are simply never copied
  always_comb begin
    msg = {32{8'h20}};
    p   = 0;
    if (strike_q == CNT_W'(WIN_STRIKES)) begin
      for (int k = 0; k < 8; k++) msg[8*k +: 8] = HOME[8*(7-k) +: 8];
    end else if (strike_q == '0 && ball_q == '0) begin
      for (int k = 0; k < 3; k++) msg[8*k +: 8] = OUT_S[8*(2-k) +: 8];
    end else begin
      for (int k = 0; k < 7; k++) msg[8*k +: 8] = STR[8*(6-k) +: 8];
      p = 7;
      if (s_bcd[7:4] != 4'd0) begin
        msg[8*p +: 8] = 8'h30 + {4'd0, s_bcd[7:4]};
        p = p + 1;
      end
      msg[8*p +: 8] = 8'h30 + {4'd0, s_bcd[3:0]};
      p = p + 1;
      for (int k = 0; k < 6; k++) msg[8*(p+k) +: 8] = BAL[8*(5-k) +: 8];
      p = p + 6;
      if (b_bcd[7:4] != 4'd0) begin
        msg[8*p +: 8] = 8'h30 + {4'd0, b_bcd[7:4]};
        p = p + 1;
      end
      msg[8*p +: 8] = 8'h30 + {4'd0, b_bcd[3:0]};
    end
  end

  // Control, conversion and line buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      strike_q <= '0;
      ball_q   <= '0;
      s_dd_q   <= '0;
      b_dd_q   <= '0;
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= xfer && last_idx;
      go_q    <= accept;
      cnt_q   <= state_q == S_CONV ? cnt_q + 3'd1 : 3'd0;
      if (accept) begin
        strike_q <= strike_count_i;
        ball_q   <= ball_count_i;
        s_dd_q   <= {8'd0, strike_count_i};
        b_dd_q   <= {8'd0, ball_count_i};
      end
      if (state_q == S_CONV) begin
        s_dd_q <= dd_step(s_dd_q);
        b_dd_q <= dd_step(b_dd_q);
      end
      if (state_q == S_COMP) line_q <= msg[LINE_LEN*8-1:0];
    end
  end
endmodule
